// File: rtl/atomrvcore_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : atomrvcore_fetch_buffer                                        |
// | Brief   : Instruction prefetch buffer. Issues word-aligned fetches over  |
// |           a req/gnt + rvalid memory port, tags every response with its   |
// |           PC and queues {instr, pc} pairs in an in-order FIFO feeding    |
// |           decode over valid/ready. A redirect flushes the FIFO, marks    |
// |           in-flight responses stale and restarts fetch.                  |
// | Options : FETCH_BYPASS_EN - when defined, a response arriving into an    |
// |           empty FIFO is presented downstream in the same cycle.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module atomrvcore_fetch_buffer #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 redirect_i,
  input  logic [DATAWIDTH-1:0] redirect_pc_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] instr_pc_o
);

  localparam int                 c_PTR_W     = $clog2(DEPTH);
  localparam int                 c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);

  // Architectural state
  logic [DATAWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [c_CNT_W-1:0]   count_q, count_d;
  logic [c_CNT_W-1:0]   outst_q, outst_d;
  logic [c_CNT_W-1:0]   drop_q, drop_d;
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0]   tag_wr_ptr_q, tag_wr_ptr_d;
  logic [c_PTR_W-1:0]   tag_rd_ptr_q, tag_rd_ptr_d;

  // Storage: instruction FIFO and the PC tags of requests still in flight
  logic [DATAWIDTH-1:0] data_mem_q [DEPTH];
  logic [DATAWIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DATAWIDTH-1:0] tag_mem_q  [DEPTH];

  logic [c_CNT_W:0]     w_credit_sum;
  logic [DATAWIDTH-1:0] w_redirect_pc;
  logic [DATAWIDTH-1:0] w_tag_head;
  logic                 w_grant;
  logic                 w_fifo_valid;
  logic                 w_drop_now;
  logic                 w_resp_keep;
  logic                 w_bypass;
  logic                 w_fifo_pop;
  logic                 w_fifo_push;

  // Credits cover both buffered words and words still in flight, so the FIFO
  // always has room for every response that can come back.
  assign w_credit_sum  = {1'b0, count_q} + {1'b0, outst_q};
  assign w_redirect_pc = redirect_pc_i & ~(DATAWIDTH'(3));
  assign imem_req_o    = !rst_i && !redirect_i && (w_credit_sum < c_DEPTH_EXT);
  assign imem_addr_o   = fetch_pc_q;
  assign w_grant       = imem_req_o && imem_gnt_i;

  assign w_tag_head    = tag_mem_q[tag_rd_ptr_q];
  assign w_fifo_valid  = (count_q != '0);
  assign w_drop_now    = (drop_q != '0);
  // A response is kept only if it is not stale and no redirect is flushing
  assign w_resp_keep   = imem_rvalid_i && !w_drop_now && !redirect_i;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = !rst_i && !redirect_i && imem_rvalid_i && !w_fifo_valid && !w_drop_now;

  // Head comes straight from the memory response when the FIFO is empty
  always_comb begin
    instr_valid_o = w_fifo_valid || w_bypass;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (w_bypass) begin
      instr_o    = imem_rdata_i;
      instr_pc_o = w_tag_head;
    end else if (w_fifo_valid) begin
      instr_o    = data_mem_q[rd_ptr_q];
      instr_pc_o = pc_mem_q[rd_ptr_q];
    end
  end
`else
  assign w_bypass = 1'b0;

  // Head comes only from registered FIFO storage
  always_comb begin
    instr_valid_o = w_fifo_valid;
    instr_o       = '0;
    instr_pc_o    = '0;
    if (w_fifo_valid) begin
      instr_o    = data_mem_q[rd_ptr_q];
      instr_pc_o = pc_mem_q[rd_ptr_q];
    end
  end
`endif

  assign w_fifo_pop  = w_fifo_valid && instr_ready_i;
  // A bypassed word consumed in the same cycle never enters the FIFO
  assign w_fifo_push = w_resp_keep && !(w_bypass && instr_ready_i);

  // Next-state for fetch PC, counters and pointers; redirect wins over all
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q;
    outst_d      = outst_q + c_CNT_W'(w_grant) - c_CNT_W'(imem_rvalid_i);
    drop_d       = drop_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_wr_ptr_d = tag_wr_ptr_q + c_PTR_W'(w_grant);
    tag_rd_ptr_d = tag_rd_ptr_q + c_PTR_W'(imem_rvalid_i);
    if (redirect_i) begin
      fetch_pc_d = w_redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Every response still in flight after this cycle is stale
      drop_d     = outst_q - c_CNT_W'(imem_rvalid_i);
    end else begin
      if (w_grant) begin
        fetch_pc_d = fetch_pc_q + DATAWIDTH'(4);
      end
      count_d  = count_q + c_CNT_W'(w_fifo_push) - c_CNT_W'(w_fifo_pop);
      drop_d   = drop_q - c_CNT_W'(imem_rvalid_i && w_drop_now);
      wr_ptr_d = wr_ptr_q + c_PTR_W'(w_fifo_push);
      rd_ptr_d = rd_ptr_q + c_PTR_W'(w_fifo_pop);
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q   <= RESET_PC;
      count_q      <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
    end
  end

  // Storage arrays need no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      tag_mem_q[tag_wr_ptr_q] <= fetch_pc_q;
    end
    if (w_fifo_push) begin
      data_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= w_tag_head;
    end
  end

  // A response into a full FIFO means the memory broke the credit contract
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(imem_rvalid_i && (count_q == c_FULL)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atomrvcore_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_atomrvcore_fetch_buffer                                     |
// | Brief   : Scoreboard bench for the fetch buffer: a memory model answers  |
// |           grants, kept responses are queued as expected {pc, instr} and  |
// |           a monitor process checks every head the DUT presents.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_atomrvcore_fetch_buffer;

  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          redirect_i = 1'b0;
  logic [DW-1:0] redirect_pc_i = '0;
  logic          imem_req_o;
  logic [DW-1:0] imem_addr_o;
  logic          imem_gnt_i = 1'b0;
  logic          imem_rvalid_i = 1'b0;
  logic [DW-1:0] imem_rdata_i = '0;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic [DW-1:0] instr_o;
  logic [DW-1:0] instr_pc_o;

  always #5 clk_i = ~clk_i;

  atomrvcore_fetch_buffer #(
    .DATAWIDTH (DW),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] due;
  } pend_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  pend_t       pend[$];   // requests granted, response not yet returned
  exp_t        sb[$];     // words expected downstream, oldest first
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  int          stale_cnt = 0;
  int          sb_start = 0;
  bit          pushed_now = 1'b0;
  logic [31:0] exp_fetch_pc = RESET_PC;
  int          grants = 0;
  int          pops = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive at negedge, account at +1, flush scoreboard at +3
  task automatic step(input logic redir, input logic [31:0] rpc, input logic gnt, input logic rdy);
    pend_t pe;
    exp_t  ee;
    logic  exp_req;
    @(negedge clk_i);
    cyc           = cyc + 1;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = gnt;
    instr_ready_i = rdy;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    sb_start   = sb.size();
    pushed_now = 1'b0;
    exp_req    = !redir && ((sb.size() + pend.size()) < DEPTH);
    chk("req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (imem_req_o) chk("addr", imem_addr_o, exp_fetch_pc);
    if (imem_rvalid_i) begin
      pe = pend.pop_front();
      if (stale_cnt > 0) begin
        stale_cnt--;
      end else if (!redir) begin
        ee.pc   = pe.pc;
        ee.data = mem_word(pe.pc);
        sb.push_back(ee);
        pushed_now = 1'b1;
      end
    end
    if (imem_req_o && gnt) begin
      pe.addr = imem_addr_o;
      pe.pc   = exp_fetch_pc;
      pe.due  = cyc + 32'($urandom_range(lat_hi, lat_lo));
      pend.push_back(pe);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      grants++;
    end
    if (redir) begin
      stale_cnt    = pend.size();
      exp_fetch_pc = rpc & ~32'h3;
    end
    #2;
    if (redir) sb.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_req",   {31'b0, imem_req_o},    32'h0);
    chk("rst_addr",  imem_addr_o,            RESET_PC);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_instr", instr_o,                32'h0);
    chk("rst_pc",    instr_pc_o,             32'h0);
  endtask

  task automatic model_reset();
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b0;
    pend.delete();
    sb.delete();
    stale_cnt    = 0;
    sb_start     = 0;
    pushed_now   = 1'b0;
    exp_fetch_pc = RESET_PC;
  endtask

  // Monitor: checks head validity and content, pops on each handshake
  initial begin
    exp_t hd;
    logic exp_valid;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        exp_valid = (sb_start > 0) || (BYP && pushed_now);
        chk("valid", {31'b0, instr_valid_o}, {31'b0, exp_valid});
        if (instr_valid_o) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head: got pc %h with nothing expected", instr_pc_o);
          end else begin
            hd = sb[0];
            chk("head_pc",   instr_pc_o, hd.pc);
            chk("head_data", instr_o,    hd.data);
            if (instr_ready_i) begin
              void'(sb.pop_front());
              pops++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0;
    int p0;
    int n;
    model_reset();
    #3;
    check_reset_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Streaming: full grant rate, one-cycle memory, always-ready consumer
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Stall: with no pops exactly DEPTH fresh grants fit
    step(1'b1, 32'h0000_0200, 1'b1, 1'b0);
    g0 = grants;
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_grants", 32'(grants - g0), 32'(DEPTH));
    g0 = grants;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("one_pop_one_grant", 32'(grants - g0), 32'd1);

    // Redirect with two requests in flight; low address bits ignored
    lat_lo = 3; lat_hi = 3;
    step(1'b1, 32'h0000_0400, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    @(posedge clk_i);
    #1;
    chk("redir_addr", imem_addr_o, 32'h0000_0100);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect together with a pop and a returning word
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'h0000_0600, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    p0 = pops;
    step(1'b1, 32'h0000_0700, 1'b0, 1'b1);
    chk("redir_pop_taken", 32'(pops - p0), 32'd1);
    @(posedge clk_i);
    #1;
    chk("redir_flush_empty", {31'b0, instr_valid_o}, 32'h0);

    // Fetch address wraps past the top of the address space
    step(1'b1, 32'hFFFF_FFF4, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of traffic
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    rst_i = 1'b1;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Randomized traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
      step($urandom_range(99) < 4, rpc, ($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    // Drain everything still in flight or buffered
    n = 0;
    while ((sb.size() != 0 || pend.size() != 0) && n < 200) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_sb",   32'(sb.size()),   32'h0);
    chk("drain_pend", 32'(pend.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
